// File: rtl/wave_dac_drv.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : wave_dac_drv                                            |
// | Brief    : Gain/offset scaling and clamping of a selected wave     |
// |            sample, then serial frame transmission to a DAC.        |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module wave_dac_drv #(
  parameter int ND  = 14,
  parameter int DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Out_En,
  input  logic [1:0]    Sel_Wave,
  input  logic [ND-1:0] Sin_in,
  input  logic [ND-1:0] Stw_in,
  input  logic [ND-1:0] Tri_in,
  input  logic [ND-1:0] Squ_in,
  input  logic [10:0]   Amp,
  input  logic [14:0]   Offset,
  output logic          dac_sclk,
  output logic          dac_sync_n,
  output logic          dac_din,
  output logic          busy,
  output logic          frame_done,
  output logic [ND-1:0] Dac_Code
);

  localparam int c_WW = ND + 2;                       // two control bits + code
  localparam int c_PW = ND + 11;
  localparam int c_SW = (ND + 3 > 17) ? ND + 3 : 17;
  localparam int c_BW = $clog2(c_WW);
  localparam int c_CW = 9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC1 = 3'd1,
    S_CALC2 = 3'd2,
    S_CALC3 = 3'd3,
    S_SHIFT = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t                 r_state, w_next;
  logic [ND-1:0]          r_wave, w_wave;
  logic [10:0]            r_amp;
  logic [14:0]            r_offset;
  logic [c_PW-1:0]        r_product;
  logic signed [c_SW-1:0] r_sum, w_sum;
  logic [c_SW-1:0]        w_scaled;
  logic [ND-1:0]          r_code, w_code;
  logic [c_WW-1:0]        r_shift;
  logic [c_CW-1:0]        r_phase;
  logic [c_BW-1:0]        r_bit;
  logic                   r_sclk, r_sync_n, r_din, r_done;
  logic [ND-1:0]          r_dac_code;
  logic                   w_phase_end, w_last_bit;

  assign w_phase_end = (r_phase == c_CW'(2 * DIV - 1));
  assign w_last_bit  = (r_bit == c_BW'(c_WW - 1));
  assign w_scaled    = c_SW'(r_product >> 10);
  assign w_sum       = $signed(w_scaled) + $signed({{(c_SW - 15){r_offset[14]}}, r_offset});

  always_comb begin
    w_wave = Sin_in;
    case (Sel_Wave)
      2'd1:    w_wave = Stw_in;
      2'd2:    w_wave = Tri_in;
      2'd3:    w_wave = Squ_in;
      default: w_wave = Sin_in;
    endcase
  end

  // Negative sums clamp to zero, anything above the code range to full scale.
  always_comb begin
    w_code = r_sum[ND-1:0];
    if (r_sum[c_SW-1])
      w_code = '0;
    else if (|r_sum[c_SW-2:ND])
      w_code = '1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Out_En) w_next = S_CALC1;
      S_CALC1: w_next = S_CALC2;
      S_CALC2: w_next = S_CALC3;
      S_CALC3: w_next = S_SHIFT;
      S_SHIFT: if (w_phase_end && w_last_bit) w_next = S_GAP;
      S_GAP:   if (w_phase_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wave    <= '0;
      r_amp     <= '0;
      r_offset  <= '0;
      r_product <= '0;
      r_sum     <= '0;
      r_code    <= '0;
      r_shift   <= '0;
      r_phase   <= '0;
      r_bit     <= '0;
    end else begin
      if (r_state == S_IDLE && Out_En) begin
        r_wave   <= w_wave;
        r_amp    <= Amp;
        r_offset <= Offset;
      end
      if (r_state == S_CALC1) r_product <= c_PW'(r_wave) * c_PW'(r_amp);
      if (r_state == S_CALC2) r_sum <= w_sum;
      if (r_state == S_CALC3) begin
        r_code  <= w_code;
        r_shift <= {2'b00, w_code};
      end else if (r_state == S_SHIFT && r_phase == '0) begin
        r_shift <= {r_shift[c_WW-2:0], 1'b0};
      end
      case (r_state)
        S_SHIFT: begin
          r_phase <= w_phase_end ? '0 : r_phase + c_CW'(1);
          if (w_phase_end) r_bit <= w_last_bit ? '0 : r_bit + c_BW'(1);
        end
        S_GAP:   r_phase <= w_phase_end ? '0 : r_phase + c_CW'(1);
        default: begin
          r_phase <= '0;
          r_bit   <= '0;
        end
      endcase
    end
  end

  // Pin outputs are registered one cycle behind the state that produces them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync_n   <= 1'b1;
      r_sclk     <= 1'b1;
      r_din      <= 1'b0;
      r_done     <= 1'b0;
      r_dac_code <= '0;
    end else begin
      r_sync_n <= 1'b1;
      r_sclk   <= 1'b1;
      r_din    <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_SHIFT: begin
          r_sync_n <= 1'b0;
          r_sclk   <= (r_phase < c_CW'(DIV));
          r_din    <= (r_phase == '0) ? r_shift[c_WW-1] : r_din;
          if (r_phase == '0 && r_bit == '0) r_dac_code <= r_code;
        end
        S_GAP:   r_done <= (r_phase == '0);
        default: ;
      endcase
    end
  end

  assign dac_sclk   = r_sclk;
  assign dac_sync_n = r_sync_n;
  assign dac_din    = r_din;
  assign frame_done = r_done;
  assign Dac_Code   = r_dac_code;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wave_dac_drv.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_wave_dac_drv                                         |
// | Brief    : Randomized self-checking bench for wave_dac_drv.        |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_wave_dac_drv;

  localparam int ND  = 14;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          Out_En = 1'b0;
  logic [1:0]    Sel_Wave = '0;
  logic [ND-1:0] Sin_in = '0, Stw_in = '0, Tri_in = '0, Squ_in = '0;
  logic [10:0]   Amp = '0;
  logic [14:0]   Offset = '0;
  logic          dac_sclk, dac_sync_n, dac_din, busy, frame_done;
  logic [ND-1:0] Dac_Code;

  int n_checks = 0;
  int n_errors = 0;

  wave_dac_drv #(.ND(ND), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .Out_En(Out_En), .Sel_Wave(Sel_Wave),
    .Sin_in(Sin_in), .Stw_in(Stw_in), .Tri_in(Tri_in), .Squ_in(Squ_in),
    .Amp(Amp), .Offset(Offset), .dac_sclk(dac_sclk), .dac_sync_n(dac_sync_n),
    .dac_din(dac_din), .busy(busy), .frame_done(frame_done), .Dac_Code(Dac_Code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference: gain in units of 1/1024, truncated, plus offset, clamped to the code range.
  function automatic int exp_code(input int wave, input int amp, input int off);
    int s;
    s = (wave * amp) / 1024 + off;
    if (s < 0) return 0;
    if (s > (1 << ND) - 1) return (1 << ND) - 1;
    return s;
  endfunction

  task automatic scramble();
    Sel_Wave = 2'($urandom_range(0, 3));
    Sin_in   = ND'($urandom);
    Stw_in   = ND'($urandom);
    Tri_in   = ND'($urandom);
    Squ_in   = ND'($urandom);
    Amp      = 11'($urandom);
    Offset   = 15'($urandom);
  endtask

  // One frame started by Out_En; k counts cycles after the capture edge T0.
  task automatic do_frame(input int sel, input int wave, input int amp, input int off,
                          input int drop_k, input int rst_k, input string tag);
    int ecode, fall_k, rise_k, done_k, n_done, n_fall_sync, nfall, busy_after, din_bad;
    int code_seen;
    logic busy138, busy139, p_sync, p_sclk, p_din;
    logic [15:0] word;
    ecode = exp_code(wave, amp, off);
    fall_k = -1; rise_k = -1; done_k = -1; n_done = 0; n_fall_sync = 0; nfall = 0;
    busy_after = 0; din_bad = 0; code_seen = -1; busy138 = 1'b0; busy139 = 1'b1;
    word = '0;
    @(negedge clk);
    scramble();
    Sel_Wave = 2'(sel);
    case (sel)
      0:       Sin_in = ND'(wave);
      1:       Stw_in = ND'(wave);
      2:       Tri_in = ND'(wave);
      default: Squ_in = ND'(wave);
    endcase
    Amp    = 11'(amp);
    Offset = 15'(off);
    Out_En = 1'b1;
    @(posedge clk);
    @(negedge clk);
    scramble();
    if (drop_k == 0) Out_En = 1'b0;
    p_sync = 1'b1; p_sclk = 1'b1; p_din = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (p_sync && !dac_sync_n) begin
        n_fall_sync++;
        if (fall_k < 0) fall_k = k;
      end
      if (!p_sync && dac_sync_n && rise_k < 0) rise_k = k;
      if (!dac_sync_n && p_sclk && !dac_sclk) begin
        word = {word[14:0], dac_din};
        nfall++;
      end
      if (dac_sync_n && dac_din) din_bad++;
      if (!dac_sync_n && !p_sync && !dac_sclk && dac_din != p_din) din_bad++;
      if (frame_done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (k == 5) code_seen = int'(Dac_Code);
      if (k == 138) busy138 = busy;
      if (k == 139) busy139 = busy;
      if (k >= 139 && busy) busy_after++;
      p_sync = dac_sync_n; p_sclk = dac_sclk; p_din = dac_din;
      if (k == drop_k) Out_En = 1'b0;
      if (k == rst_k) begin
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_sync_n"}, 32'(dac_sync_n), 1);
        check({tag, "_sclk"}, 32'(dac_sclk), 1);
        check({tag, "_din"}, 32'(dac_din), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(frame_done), 0);
        check({tag, "_code"}, 32'(Dac_Code), 0);
        check({tag, "_prior_code"}, 32'(code_seen), 32'(ecode));
        rst = 1'b1;
        return;
      end
      @(negedge clk);
    end
    check({tag, "_sync_fall"}, 32'(fall_k), 4);
    check({tag, "_sync_rise"}, 32'(rise_k), 132);
    check({tag, "_done_at"}, 32'(done_k), 132);
    check({tag, "_done_cnt"}, 32'(n_done), 1);
    check({tag, "_frames"}, 32'(n_fall_sync), 1);
    check({tag, "_sclk_falls"}, 32'(nfall), 16);
    check({tag, "_word"}, 32'(word), 32'(ecode));
    check({tag, "_code"}, 32'(code_seen), 32'(ecode));
    check({tag, "_code_hold"}, 32'(Dac_Code), 32'(ecode));
    check({tag, "_din_bad"}, 32'(din_bad), 0);
    check({tag, "_busy138"}, 32'(busy138), 1);
    check({tag, "_busy139"}, 32'(busy139), 0);
    check({tag, "_busy_after"}, 32'(busy_after), 0);
  endtask

  task automatic run_continuous();
    int falls[$];
    int rises[$];
    int wins[$];
    int cur, idle_k;
    logic p_sync, p_sclk;
    cur = 0; idle_k = -1;
    @(negedge clk);
    Sel_Wave = 2'd0; Sin_in = ND'(1000); Amp = 11'd1024; Offset = '0;
    Out_En = 1'b1;
    p_sync = 1'b1; p_sclk = 1'b1;
    for (int k = 0; k < 460; k++) begin
      @(negedge clk);
      if (p_sync && !dac_sync_n) begin falls.push_back(k); cur = 0; end
      if (!p_sync && dac_sync_n) begin rises.push_back(k); wins.push_back(cur); end
      if (!dac_sync_n && p_sclk && !dac_sclk) cur++;
      p_sync = dac_sync_n; p_sclk = dac_sclk;
    end
    Out_En = 1'b0;
    check("cont_nfalls", 32'(falls.size()), 4);
    check("cont_nrises", 32'(rises.size()), 3);
    if (falls.size() >= 3 && rises.size() >= 2) begin
      check("cont_first_fall", 32'(falls[0]), 4);
      check("cont_period0", 32'(falls[1] - falls[0]), 140);
      check("cont_period1", 32'(falls[2] - falls[1]), 140);
      check("cont_low_width", 32'(rises[0] - falls[0]), 128);
      check("cont_high_width", 32'(falls[1] - rises[0]), 12);
      check("cont_win0_edges", 32'(wins[0]), 16);
      check("cont_win1_edges", 32'(wins[1]), 16);
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy && idle_k < 0) idle_k = k;
    end
    check("cont_stop_idle_seen", 32'(idle_k >= 0), 1);
    check("cont_stop_busy", 32'(busy), 0);
    check("cont_stop_sync", 32'(dac_sync_n), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sel, wave, amp, off;
    rst = 1'b0;
    Out_En = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sync_n", 32'(dac_sync_n), 1);
    check("rst_sclk", 32'(dac_sclk), 1);
    check("rst_din", 32'(dac_din), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_code", 32'(Dac_Code), 0);
    Out_En = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    do_frame(0, 8192, 1024, 0, 0, -1, "sin_unity");
    do_frame(1, 16383, 2047, 100, 0, -1, "stw_sat_hi");
    do_frame(2, 100, 1024, -500, 0, -1, "tri_sat_lo");
    do_frame(3, 16383, 512, 100, 0, -1, "squ_half");
    for (int i = 0; i < 6; i++) begin
      sel  = int'($urandom_range(0, 3));
      wave = int'($urandom_range(0, 16383));
      amp  = int'($urandom_range(0, 2047));
      off  = int'($urandom_range(0, 32767)) - 16384;
      do_frame(sel, wave, amp, off, 0, -1, $sformatf("rand%0d", i));
    end
    do_frame(1, 12000, 900, -37, 46, -1, "drop_bit5");
    do_frame(2, 9000, 1500, 250, 0, 62, "rst_bit7");
    do_frame(0, 5000, 1024, -20, 0, -1, "after_rst");
    run_continuous();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
